dsp48_mac_sequencer: RTL and testbench
======================================

Name: dsp48_mac_sequencer

Overview:
- Controller that runs one DSP48A1 slice as a multiply-accumulate engine.
- Takes a job (element count, add/subtract mode) and streams operand pairs in over a valid/ready handshake.
- Drives the slice's A/B data, OPMODE and clock-enable ports; tracks each operand through the slice pipeline; returns the final P over a valid/ready result interface.
- Target slice configuration: A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT", CARRYINSEL="OPMODE5"; sequencer timing assumes exactly this.

Parameters:
LEN_W, 10, width of job length and element counter (max job 2^LEN_W-1 elements)

Ports:
clk  in  1  clock; sole clock domain
rst_n  in  1  asynchronous, active-low reset
start  in  1  job request; sampled only in IDLE
len  in  LEN_W  number of operand pairs in the job, captured on start
acc_sub  in  1  captured on start; 1 = subtract elements 2..N from accumulator
busy  out  1  high in any state other than IDLE
op_valid  in  1  operand pair valid
op_ready  out  1  sequencer accepts operand this cycle
op_a  in  18  operand A (unsigned)
op_b  in  18  operand B (unsigned)
dsp_a  out  18  to slice A; equals op_a combinationally
dsp_b  out  18  to slice B; equals op_b combinationally
dsp_cea  out  1  to slice CEA
dsp_ceb  out  1  to slice CEB
dsp_cem  out  1  to slice CEM
dsp_ceopmode  out  1  to slice CEOPMODE
dsp_cep  out  1  to slice CEP
dsp_opmode  out  8  to slice OPMODE
dsp_p  in  48  from slice P
res_valid  out  1  result available
res_ready  in  1  result consumer ready
result  out  48  accumulated result, stable while res_valid

Behaviour:
- Reset (async, rst_n low): state IDLE; busy=0, op_ready=0, dsp_cea/ceb/cem/cep=0, dsp_ceopmode=1, dsp_opmode=8'h00, res_valid=0, result=0, tag pipe cleared, counter=0.
- States:
  - IDLE: start=1 and len!=0 -> RUN, load remaining=len and acc_sub. start=1 and len==0 -> DONE with result=0 on the next cycle.
  - RUN: op_ready = (remaining!=0). Accept = op_valid & op_ready; each accept decrements remaining. Accept of the final element -> DRAIN.
  - DRAIN: op_ready=0; wait until the last-tagged element has been captured into P, then load result<=dsp_p on the following edge -> DONE.
  - DONE: res_valid=1. res_valid & res_ready -> IDLE, same edge. start is ignored in every state except IDLE.
- Slice enables:
  - dsp_cea = dsp_ceb = accept, so A1/B1 load only accepted data.
  - dsp_cem = busy.
  - dsp_ceopmode = 1 always.
- Tag pipe: two stages {valid, first, last}.
  - s1 loads the accept tag at each edge; s2 loads s1.
  - s1 valid = element is in A1/B1 (M computing). s2 valid = element is in M (adder computing).
- OPMODE is driven from s1, so the OPMODE register holds the matching value while the element is in M:
  - s1 first: 8'h01 (X=M, Z=0, add).
  - s1 not first, acc_sub=0: 8'h09 (X=M, Z=P, add).
  - s1 not first, acc_sub=1: 8'h89 (Z=P minus X=M).
  - s1 invalid (bubble): 8'h08 (X=0, Z=P).
  - Bits 4,5,6 are always 0: no pre-adder, no carry-in.
- dsp_cep = s2.valid. P updates only on real elements; bubbles never disturb the accumulator.
- Latency:
  - Accept in cycle 0 -> A1/B1 at edge 1 -> M at edge 2 -> P at edge 3.
  - Last accept -> result loaded at edge 4; res_valid high from cycle 4.
  - Throughput: one element per cycle; the next job may start the cycle after the result handshake.
- Arithmetic: 36-bit unsigned products; 48-bit accumulation wraps modulo 2^48. CARRYOUT is not used.
- len==1: the single element is both first and last; result = a*b.
- Result backpressure: res_valid and result hold indefinitely until res_ready.
- Reset mid-job: immediate return to IDLE; the in-flight tag pipe is discarded. The next job's first element uses Z=0, so no P reset pulse is needed.

Decomposition:
- Shared package dsp_seq_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - OPMODE constants OPM_FIRST=8'h01, OPM_ACC=8'h09, OPM_SUB=8'h89, OPM_HOLD=8'h08;
  - tag struct {valid, first, last}.
- One sub-module, dsp_tag_pipe: the two-stage tag shift register with async active-low clear.
- Bench instantiates DSP48A1 with the configuration above, connected to the dsp_* ports.

Test Plan:
- len=3, acc_sub=0, pairs (2,3),(4,5),(1,6) back-to-back -> result=32; res_valid exactly 4 cycles after last accept.
- len=3, acc_sub=1, pairs (10,10),(2,3),(1,4) -> result=90; dsp_opmode sequence 01,89,89.
- len=4, op_valid gaps of 0-3 cycles between pairs (1,1),(2,2),(3,3),(4,4) -> result=30; dsp_cep high exactly 4 cycles total.
- len=0 start -> res_valid next cycle, result=0. start pulses while in RUN/DONE are ignored.
- res_ready held low 10 cycles -> result and res_valid stable. Assert res_ready -> IDLE next cycle; new job len=1 (7,9) -> 63.
- rst_n low mid-RUN of len=5 after 2 accepts -> all outputs return to reset values asynchronously; new job len=2 (3,3),(1,1) -> result=10.

Source files
------------

// File: rtl/dsp_seq_pkg.sv
// Shared types and OPMODE encodings for the DSP48A1 MAC sequencer.
package dsp_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // OPMODE = {sub, pre_sub, cin, pre_en, Z[1:0], X[1:0]}
  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_SUB   = 8'h89;
  localparam logic [7:0] OPM_HOLD  = 8'h08;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/dsp_tag_pipe.sv
// Two-stage tag shift register that follows each operand through A1/B1 and M.
module dsp_tag_pipe
  import dsp_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t s1,
  output tag_t s2
);

  localparam int STAGES = 2;

  tag_t [STAGES:1] tag_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pipe <= '0;
    end else begin
      for (int i = STAGES; i > 1; i--) tag_pipe[i] <= tag_pipe[i-1];
      tag_pipe[1] <= tag_in;
    end
  end

  assign s1 = tag_pipe[1];
  assign s2 = tag_pipe[2];

endmodule

// File: rtl/dsp48_mac_sequencer.sv
// Runs one DSP48A1 slice (A1/B1, M, OPMODE, P registered) as a streaming MAC.
module dsp48_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             acc_sub,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [17:0]      op_a,
  input  logic [17:0]      op_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_ceopmode,
  output logic             dsp_cep,
  output logic [7:0]       dsp_opmode,
  input  logic [47:0]      dsp_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      result
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining;
  logic             sub_q;
  logic             first_q;
  logic             p_last;
  logic [47:0]      result_q;
  logic             accept;
  tag_t             tag_in, s1, s2;
  logic             unused_tag;

  assign busy         = (state != IDLE);
  assign op_ready     = (state == RUN) && (remaining != '0);
  assign accept       = op_valid & op_ready;
  assign dsp_a        = op_a;
  assign dsp_b        = op_b;
  assign dsp_cea      = accept;
  assign dsp_ceb      = accept;
  assign dsp_cem      = busy;
  assign dsp_ceopmode = 1'b1;
  assign dsp_cep      = s2.valid;
  assign res_valid    = (state == DONE);
  assign result       = result_q;
  assign unused_tag   = s1.last ^ s2.first;

  assign tag_in = '{valid: accept,
                    first: accept & first_q,
                    last:  accept & (remaining == LEN_W'(1))};

  dsp_tag_pipe u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_in (tag_in),
    .s1     (s1),
    .s2     (s2)
  );

  // Driven from s1 so the OPMODE register lines up with the element sitting in M.
  always_comb begin
    dsp_opmode = busy ? OPM_HOLD : 8'h00;
    if (s1.valid) dsp_opmode = s1.first ? OPM_FIRST : (sub_q ? OPM_SUB : OPM_ACC);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (len != '0) ? RUN : DONE;
      RUN:   if (accept && remaining == LEN_W'(1)) state_nxt = DRAIN;
      DRAIN: if (p_last) state_nxt = DONE;
      DONE:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      sub_q     <= 1'b0;
      first_q   <= 1'b0;
      p_last    <= 1'b0;
      result_q  <= '0;
    end else begin
      state  <= state_nxt;
      // High in the cycle after the last element has landed in P.
      p_last <= s2.valid & s2.last;
      case (state)
        IDLE: if (start) begin
          remaining <= len;
          sub_q     <= acc_sub;
          first_q   <= 1'b1;
          if (len == '0) result_q <= '0;
        end
        RUN: if (accept) begin
          remaining <= remaining - LEN_W'(1);
          first_q   <= 1'b0;
        end
        DRAIN: if (p_last) result_q <= dsp_p;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp48_mac_sequencer.sv
// Sequencer driving a behavioural DSP48A1 slice, checked against a result scoreboard.
module tb_dsp48_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  len = '0;
  logic        acc_sub = 1'b0;
  logic        busy;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [17:0] op_a = '0, op_b = '0;
  logic [17:0] dsp_a, dsp_b;
  logic        dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [47:0] result;

  always #5 clk = ~clk;

  dsp48_mac_sequencer #(.LEN_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .acc_sub(acc_sub),
    .busy(busy), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb),
    .dsp_cem(dsp_cem), .dsp_ceopmode(dsp_ceopmode), .dsp_cep(dsp_cep),
    .dsp_opmode(dsp_opmode), .dsp_p(dsp_p), .res_valid(res_valid),
    .res_ready(res_ready), .result(result)
  );

  // Slice model: A1/B1, M, OPMODE and P registers; no slice reset is wired.
  logic [17:0] a1 = '0, b1 = '0;
  logic [35:0] m = '0;
  logic [7:0]  opm_r = '0;
  logic [47:0] p = '0;
  logic [47:0] xm, zm, alu;

  always_comb begin
    xm  = (opm_r[1:0] == 2'b01) ? {12'b0, m} : 48'b0;
    zm  = (opm_r[3:2] == 2'b10) ? p : 48'b0;
    alu = opm_r[7] ? zm - xm : zm + xm;
  end

  always @(posedge clk) begin
    if (dsp_cea) a1 <= dsp_a;
    if (dsp_ceb) b1 <= dsp_b;
    if (dsp_cem) m <= {18'b0, a1} * {18'b0, b1};
    if (dsp_ceopmode) opm_r <= dsp_opmode;
    if (dsp_cep) p <= alu;
  end
  assign dsp_p = p;

  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, cep_cnt = 0, last_acc_cyc = 0;
  logic [47:0] sb[$];
  logic [7:0]  opm_log[$];
  int          va[$], vb[$];

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (dsp_cep) cep_cnt++;
    if (busy && dsp_opmode != 8'h08 && dsp_opmode != 8'h00) opm_log.push_back(dsp_opmode);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send_job(input int n, input bit sub, input int gapmax, input bit pulse_mid);
    logic [47:0] acc, pr;
    int t;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      pr  = 48'(va[i]) * 48'(vb[i]);
      acc = (i == 0) ? pr : (sub ? acc - pr : acc + pr);
    end
    sb.push_back(acc);
    @(negedge clk); start = 1'b1; len = 10'(n); acc_sub = sub;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gapmax > 0) repeat ($urandom_range(0, gapmax)) @(negedge clk);
      op_valid = 1'b1; op_a = 18'(va[i]); op_b = 18'(vb[i]);
      t = 0;
      while (!op_ready && t < 50) begin @(negedge clk); t++; end
      if (!op_ready) chk("op_ready_timeout", op_ready, 1);
      if (i == 0) chk("dsp_a_passthru", dsp_a, op_a);
      last_acc_cyc = cyc;
      @(negedge clk); op_valid = 1'b0;
      if (pulse_mid && i == 0) begin
        start = 1'b1; len = 10'd7;
        @(negedge clk); start = 1'b0;
      end
    end
  endtask

  task automatic get_result(input int hold, input bit chk_lat);
    int t;
    bit stable;
    logic [47:0] r0, exp;
    t = 0;
    while (!res_valid && t < 100) begin @(negedge clk); t++; end
    chk("res_valid", res_valid, 1);
    if (chk_lat) chk("latency", cyc - last_acc_cyc, 4);
    r0 = result; stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!res_valid || result !== r0 || !busy) stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", stable, 1);
    res_ready = 1'b1;
    exp = (sb.size() > 0) ? sb.pop_front() : 48'hdead;
    chk("result", result, exp);
    @(negedge clk); res_ready = 1'b0;
    chk("idle_after_hs", busy, 0);
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_op_ready"}, op_ready, 0);
    chk({pfx, "_ce_abmp"}, {dsp_cea, dsp_ceb, dsp_cem, dsp_cep}, 4'b0);
    chk({pfx, "_ceopmode"}, dsp_ceopmode, 1);
    chk({pfx, "_opmode"}, dsp_opmode, 8'h00);
    chk({pfx, "_res_valid"}, res_valid, 0);
    chk({pfx, "_result"}, result, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cep0, opm0;
    logic [7:0] exp_opm [3];
    exp_opm = '{8'h01, 8'h89, 8'h89};

    repeat (2) @(negedge clk);
    chk_reset_outs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // back-to-back accumulate with latency check
    va = '{2, 4, 1}; vb = '{3, 5, 6};
    send_job(3, 1'b0, 0, 1'b0);
    get_result(0, 1'b1);

    // subtract mode and OPMODE sequence
    va = '{10, 2, 1}; vb = '{10, 3, 4};
    opm0 = opm_log.size();
    send_job(3, 1'b1, 0, 1'b0);
    get_result(0, 1'b1);
    chk("opm_count", opm_log.size() - opm0, 3);
    for (int i = 0; i < 3; i++)
      if (opm0 + i < opm_log.size()) chk("opm_seq", opm_log[opm0 + i], exp_opm[i]);

    // gaps between operands; P must only update on real elements
    va = '{1, 2, 3, 4}; vb = '{1, 2, 3, 4};
    cep0 = cep_cnt;
    send_job(4, 1'b0, 3, 1'b0);
    get_result(0, 1'b1);
    chk("cep_count", cep_cnt - cep0, 4);

    // len==0 job, start ignored in DONE
    @(negedge clk); start = 1'b1; len = 10'd0; sb.push_back(48'd0);
    @(negedge clk); start = 1'b0;
    chk("len0_valid_next", res_valid, 1);
    start = 1'b1; len = 10'd5;
    @(negedge clk); start = 1'b0;
    chk("len0_start_ignored", {res_valid, busy}, 2'b11);
    get_result(0, 1'b0);

    // start ignored in RUN
    va = '{5, 6}; vb = '{7, 8};
    send_job(2, 1'b0, 0, 1'b1);
    get_result(0, 1'b1);

    // backpressure, then single-element job
    va = '{7}; vb = '{9};
    send_job(1, 1'b0, 0, 1'b0);
    get_result(10, 1'b1);

    // full-scale operands: 36-bit unsigned products
    va = '{18'h3ffff, 18'h3ffff}; vb = '{18'h3ffff, 18'h20000};
    send_job(2, 1'b0, 1, 1'b0);
    get_result(0, 1'b1);

    // reset in the middle of a len=5 job after two accepts
    @(negedge clk); start = 1'b1; len = 10'd5; acc_sub = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_valid = 1'b1; op_a = 18'(i + 11); op_b = 18'(i + 13);
      @(negedge clk);
    end
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("midrst");
    op_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    va = '{3, 1}; vb = '{3, 1};
    send_job(2, 1'b0, 0, 1'b0);
    get_result(0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
